video_mem_ctrl: RTL and testbench

VIDEO_MEM_CTRL -- requirements
Module: video_mem_ctrl

---
 rtl/video_mem_ctrl.sv | 138 +++++++++++++
 tb/tb_video_mem_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mem_ctrl.sv
// Double-buffered 1-bit cell bitmap for the VGA pixel stage.
// Writes and clears touch the back bank; a swap copies it to the front bank at vertical blank.
module video_mem_ctrl #(
  parameter int unsigned GRID_CELLS = 100,
  parameter int unsigned ADDR_W     = 7
) (
  input  logic                  clk_25m,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic                  wr_data,
  input  logic                  clr_req,
  input  logic                  swap_req,
  input  logic                  frame_start,
  output logic [GRID_CELLS-1:0] video_memory,
  output logic                  busy,
  output logic [7:0]            frame_cnt,
  output logic                  addr_err
);

  localparam int unsigned SLICE_W     = 10;
  localparam int unsigned NUM_SLICES  = (GRID_CELLS + SLICE_W - 1) / SLICE_W;
  localparam int unsigned SLICE_CNT_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int unsigned IDX_W       = (GRID_CELLS > 1) ? $clog2(GRID_CELLS) : 1;
  localparam logic [SLICE_CNT_W-1:0] LAST_SLICE = SLICE_CNT_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [GRID_CELLS-1:0]  back;
  logic [GRID_CELLS-1:0]  back_nxt;
  logic [SLICE_CNT_W-1:0] slice_cnt;
  logic [SLICE_CNT_W-1:0] slice_cnt_nxt;
  logic                   do_write;
  logic                   do_clear;
  logic                   do_swap;
  logic                   addr_ok;

  assign addr_ok = (32'(wr_addr) < GRID_CELLS);

  // State register
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; only one IDLE request wins, the rest are dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
        end else if (swap_req) begin
          state_nxt = SWAP_WAIT;
        end
      end
      CLEAR: begin
        if (slice_cnt == LAST_SLICE) begin
          state_nxt = IDLE;
        end
      end
      SWAP_WAIT: begin
        if (frame_start) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath controls decoded from the current state
  always_comb begin
    do_write = 1'b0;
    do_clear = 1'b0;
    do_swap  = 1'b0;
    case (state)
      IDLE:      do_write = wr_valid && !clr_req && !swap_req;
      CLEAR:     do_clear = 1'b1;
      SWAP_WAIT: do_swap  = frame_start;
      default: begin
        do_write = 1'b0;
      end
    endcase
  end

  // Back-bank update: single-cell write or one 10-bit clear slice
  always_comb begin
    back_nxt      = back;
    slice_cnt_nxt = slice_cnt;
    if (do_write && addr_ok) begin
      back_nxt[IDX_W'(wr_addr)] = wr_data;
    end
    if (do_clear) begin
      for (int unsigned i = 0; i < GRID_CELLS; i++) begin
        if (SLICE_CNT_W'(i / SLICE_W) == slice_cnt) begin
          back_nxt[IDX_W'(i)] = 1'b0;
        end
      end
      slice_cnt_nxt = (slice_cnt == LAST_SLICE) ? '0 : slice_cnt + SLICE_CNT_W'(1);
    end
  end

  // Banks, counters and registered status outputs
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      back         <= '0;
      video_memory <= '0;
      slice_cnt    <= '0;
      frame_cnt    <= 8'd0;
      addr_err     <= 1'b0;
      busy         <= 1'b0;
      wr_ready     <= 1'b1;
    end else begin
      back      <= back_nxt;
      slice_cnt <= slice_cnt_nxt;
      busy      <= (state_nxt != IDLE);
      wr_ready  <= (state_nxt == IDLE);
      if (do_write && !addr_ok) begin
        addr_err <= 1'b1;
      end
      if (do_swap) begin
        video_memory <= back;
        frame_cnt    <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_video_mem_ctrl.sv
// Self-checking bench for video_mem_ctrl: bench-side bank model feeds a swap scoreboard.
module tb_video_mem_ctrl;

  localparam int unsigned GRID_CELLS = 100;
  localparam int unsigned ADDR_W     = 7;

  logic                  clk_25m;
  logic                  rst_n;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_W-1:0]     wr_addr;
  logic                  wr_data;
  logic                  clr_req;
  logic                  swap_req;
  logic                  frame_start;
  logic [GRID_CELLS-1:0] video_memory;
  logic                  busy;
  logic [7:0]            frame_cnt;
  logic                  addr_err;

  video_mem_ctrl #(
    .GRID_CELLS(GRID_CELLS),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk_25m     (clk_25m),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .clr_req     (clr_req),
    .swap_req    (swap_req),
    .frame_start (frame_start),
    .video_memory(video_memory),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .addr_err    (addr_err)
  );

  typedef struct {
    logic [GRID_CELLS-1:0] mem;
    logic [7:0]            cnt;
  } sb_item_t;

  sb_item_t              sb[$];
  sb_item_t              mon_item;
  logic [7:0]            prev_cnt;
  logic [GRID_CELLS-1:0] mdl_back;
  logic [GRID_CELLS-1:0] mdl_front;
  logic [7:0]            mdl_cnt;
  logic                  mdl_err;
  int                    checks;
  int                    failures;

  initial clk_25m = 1'b0;
  always #20 clk_25m = ~clk_25m;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_25m);
    #1;
  endtask

  // Every frame_cnt change outside reset must match the oldest pending swap
  always begin
    @(posedge clk_25m);
    #1;
    if (!rst_n) begin
      prev_cnt = 8'd0;
    end else if (frame_cnt !== prev_cnt) begin
      if (sb.size() == 0) begin
        check("unexpected_swap", 128'(frame_cnt), 128'(prev_cnt));
      end else begin
        mon_item = sb.pop_front();
        check("sb_video_memory", 128'(video_memory), 128'(mon_item.mem));
        check("sb_frame_cnt", 128'(frame_cnt), 128'(mon_item.cnt));
      end
      prev_cnt = frame_cnt;
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_video_memory", 128'(video_memory), 128'(0));
    check("rst_frame_cnt", 128'(frame_cnt), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_addr_err", 128'(addr_err), 128'(0));
    check("rst_sb_empty", 128'(sb.size()), 128'(0));
    step();
    step();
    rst_n     = 1'b1;
    mdl_back  = '0;
    mdl_front = '0;
    mdl_cnt   = 8'd0;
    mdl_err   = 1'b0;
    check("rst_wr_ready", 128'(wr_ready), 128'(1));
  endtask

  task automatic write_cell(input int unsigned addr, input logic data);
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(addr);
    wr_data  = data;
    step();
    wr_valid = 1'b0;
    if (addr < GRID_CELLS) mdl_back[addr] = data;
    else mdl_err = 1'b1;
  endtask

  task automatic swap_frame(input int gap);
    sb_item_t it;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    check("swap_wr_ready", 128'(wr_ready), 128'(0));
    for (int i = 1; i < gap; i++) begin
      check("swap_busy", 128'(busy), 128'(1));
      check("swap_hold_front", 128'(video_memory), 128'(mdl_front));
      step();
    end
    check("swap_busy", 128'(busy), 128'(1));
    it.mem = mdl_back;
    it.cnt = mdl_cnt + 8'd1;
    sb.push_back(it);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    mdl_front = mdl_back;
    mdl_cnt   = mdl_cnt + 8'd1;
    check("swap_done_busy", 128'(busy), 128'(0));
  endtask

  // Accepts clr_req (plus any other requests the caller raised) and tracks the 10 busy cycles
  task automatic clear_back();
    clr_req = 1'b1;
    step();
    clr_req  = 1'b0;
    swap_req = 1'b0;
    wr_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("clr_busy", 128'(busy), 128'(1));
      check("clr_wr_ready", 128'(wr_ready), 128'(0));
      check("clr_hold_front", 128'(video_memory), 128'(mdl_front));
      if (i == 4) begin
        frame_start = 1'b1;
        wr_valid    = 1'b1;
        wr_addr     = ADDR_W'(7);
        wr_data     = 1'b1;
      end
      step();
      frame_start = 1'b0;
      wr_valid    = 1'b0;
    end
    check("clr_done_busy", 128'(busy), 128'(0));
    check("clr_done_wr_ready", 128'(wr_ready), 128'(1));
    mdl_back = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    prev_cnt    = 8'd0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = 1'b0;
    clr_req     = 1'b0;
    swap_req    = 1'b0;
    frame_start = 1'b0;
    apply_reset();

    // Write then swap, frame_start three cycles after the swap request
    write_cell(5, 1'b1);
    write_cell(99, 1'b1);
    check("ws_front_still_zero", 128'(video_memory), 128'(0));
    swap_frame(3);
    check("ws_frame_cnt", 128'(frame_cnt), 128'(1));

    // Clear timing: back all ones, publish, clear, publish zeros
    for (int unsigned a = 0; a < GRID_CELLS; a++) write_cell(a, 1'b1);
    swap_frame(2);
    clear_back();
    swap_frame(2);
    check("clr_front_zero", 128'(video_memory), 128'(0));

    // Priority: clear beats swap and write in the same cycle
    apply_reset();
    swap_req = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(3);
    wr_data  = 1'b1;
    clear_back();
    swap_frame(2);
    check("prio_front", 128'(video_memory), 128'(0));
    check("prio_frame_cnt", 128'(frame_cnt), 128'(1));

    // Out-of-range writes set a sticky flag and leave back alone
    write_cell(20, 1'b1);
    write_cell(100, 1'b1);
    write_cell(127, 1'b1);
    check("bad_addr_err", 128'(addr_err), 128'(1));
    write_cell(10, 1'b1);
    swap_frame(1);
    check("bad_addr_sticky", 128'(addr_err), 128'(mdl_err));

    // frame_start coincident with the swap accept does not complete it
    write_cell(42, 1'b1);
    swap_req    = 1'b1;
    frame_start = 1'b1;
    step();
    swap_req    = 1'b0;
    frame_start = 1'b0;
    check("coinc_busy", 128'(busy), 128'(1));
    check("coinc_cnt", 128'(frame_cnt), 128'(mdl_cnt));
    check("coinc_front", 128'(video_memory), 128'(mdl_front));
    step();
    begin
      sb_item_t it;
      it.mem = mdl_back;
      it.cnt = mdl_cnt + 8'd1;
      sb.push_back(it);
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    mdl_front = mdl_back;
    mdl_cnt   = mdl_cnt + 8'd1;
    check("coinc_done_busy", 128'(busy), 128'(0));
    check("coinc_err_sticky", 128'(addr_err), 128'(1));

    // 256 swaps wrap frame_cnt back to zero
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      write_cell(i % 100, ((i / 100) % 2) == 0);
      swap_frame(1);
    end
    check("wrap_frame_cnt", 128'(frame_cnt), 128'(0));

    // Reset in the 4th cycle of CLEAR aborts with no residual swap
    write_cell(50, 1'b1);
    write_cell(120, 1'b1);
    swap_frame(1);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    step();
    step();
    #5;
    apply_reset();
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("rc_busy", 128'(busy), 128'(0));
    check("rc_frame_cnt", 128'(frame_cnt), 128'(0));
    check("rc_front", 128'(video_memory), 128'(0));
    swap_frame(1);

    // Reset during SWAP_WAIT aborts the pending swap
    apply_reset();
    write_cell(60, 1'b1);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    step();
    #5;
    apply_reset();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("rs_busy", 128'(busy), 128'(0));
    check("rs_frame_cnt", 128'(frame_cnt), 128'(0));
    check("rs_front", 128'(video_memory), 128'(0));
    swap_frame(1);

    step();
    step();
    check("end_sb_empty", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
